// File: rtl/enc_pkg.sv
// Shared definitions for the LFSR message encryptor.
//   - enc_state_t : encryptor FSM states
//   - constants   : ASCII offset, default memory map, LFSR width, clamp floor
//   - parity7     : even-parity bit over a 7-bit value (bit 7 of each output byte)
package enc_pkg;

  localparam int LFSR_W = 7;

  localparam int MSG_LEN_D = 52;
  localparam int OUT_LEN_D = 64;

  localparam logic [7:0] OUT_BASE_D  = 8'd64;
  localparam logic [7:0] PRE_ADDR_D  = 8'd61;
  localparam logic [7:0] TAP_ADDR_D  = 8'd62;
  localparam logic [7:0] SEED_ADDR_D = 8'd63;
  localparam logic [3:0] MIN_PRE_D   = 4'd10;

  localparam logic [7:0] ASCII_OFFSET = 8'h20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD0  = 3'd1,
    LD1  = 3'd2,
    LD2  = 3'd3,
    LD3  = 3'd4,
    RD   = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } enc_state_t;

  function automatic logic parity7(input logic [LFSR_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR used as the encryption keystream.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high; clears the register to zero
//   load  : load seed (a zero seed becomes 7'h01 so the sequence never locks up)
//   seed  : seed value used on load
//   taps  : feedback tap mask; feedback bit is the XOR of state & taps
//   step  : advance one position (shift left, feedback into bit 0)
//   state : current LFSR value
module lfsr7
  import enc_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] taps,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_encryptor.sv
// LFSR message encryptor. Reads the preamble length, tap mask and seed from
// data memory, then walks 64 output positions: each position takes either a
// message character (offset by -0x20) or zero for preamble/padding, XORs it
// with the keystream, adds an even-parity bit in bit 7 and writes the result
// to OUT_BASE+index.
//   Clk         : clock, rising edge
//   Reset       : synchronous, active-high
//   Start       : high holds the block idle; low launches a run from IDLE,
//                 high in DONE returns to IDLE
//   Ack         : registered run-complete flag, high while in DONE
//   mem_addr    : data-memory address
//   mem_rd_data : read data, one cycle after mem_addr
//   mem_wr_en   : write strobe (WR state only)
//   mem_wr_data : write data
module lfsr_encryptor
  import enc_pkg::*;
#(
  parameter int         MSG_LEN   = MSG_LEN_D,
  parameter int         OUT_LEN   = OUT_LEN_D,
  parameter logic [7:0] OUT_BASE  = OUT_BASE_D,
  parameter logic [7:0] PRE_ADDR  = PRE_ADDR_D,
  parameter logic [7:0] TAP_ADDR  = TAP_ADDR_D,
  parameter logic [7:0] SEED_ADDR = SEED_ADDR_D,
  parameter logic [3:0] MIN_PRE   = MIN_PRE_D
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  enc_state_t        fsm_state;
  enc_state_t        fsm_next;
  logic [7:0]        index;
  logic [3:0]        pre;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_load;
  logic              lfsr_step;

  logic              in_window;
  logic [7:0]        msg_addr;
  logic [7:0]        padded;
  logic [LFSR_W-1:0] c7;
  logic [7:0]        cipher;

  function automatic logic [3:0] clamp_pre(input logic [3:0] raw);
    return (raw < MIN_PRE) ? MIN_PRE : raw;
  endfunction

  lfsr7 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (lfsr_load),
    .seed  (mem_rd_data[LFSR_W-1:0]),
    .taps  (taps),
    .step  (lfsr_step),
    .state (lfsr)
  );

  // Message window pre <= index < pre+MSG_LEN, evaluated at 9 bits so the
  // upper bound cannot wrap; the 64-entry output walk clips it naturally.
  always_comb begin
    in_window = ({1'b0, index} >= {5'b0, pre}) &&
                ({1'b0, index} <  ({5'b0, pre} + 9'(MSG_LEN)));
    msg_addr  = index - {4'b0, pre};
    padded    = in_window ? (mem_rd_data - ASCII_OFFSET) : 8'h00;
    c7        = padded[LFSR_W-1:0] ^ lfsr;
    cipher    = {parity7(c7), c7};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_state <= IDLE;
      index     <= '0;
      Ack       <= 1'b0;
    end else begin
      fsm_state <= fsm_next;
      Ack       <= (fsm_next == DONE);
      if (fsm_state == LD3) begin
        index <= '0;
      end else if (fsm_state == WR) begin
        index <= index + 8'd1;
      end
    end
  end

  // Run parameters are plain data captured from the read port; they are
  // always reloaded before use, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (fsm_state == LD1) begin
      pre <= clamp_pre(mem_rd_data[3:0]);
    end
    if (fsm_state == LD2) begin
      taps <= mem_rd_data[LFSR_W-1:0];
    end
  end

  always_comb begin
    fsm_next    = fsm_state;
    mem_addr    = 8'h00;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    case (fsm_state)
      IDLE: begin
        if (!Start) begin
          fsm_next = LD0;
        end
      end
      LD0: begin
        mem_addr = PRE_ADDR;
        fsm_next = LD1;
      end
      LD1: begin
        mem_addr = TAP_ADDR;
        fsm_next = LD2;
      end
      LD2: begin
        mem_addr = SEED_ADDR;
        fsm_next = LD3;
      end
      LD3: begin
        lfsr_load = 1'b1;
        fsm_next  = RD;
      end
      RD: begin
        if (in_window) begin
          mem_addr = msg_addr;
        end
        fsm_next = WR;
      end
      WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = OUT_BASE + index;
        mem_wr_data = cipher;
        lfsr_step   = 1'b1;
        fsm_next    = (index == 8'(OUT_LEN - 1)) ? DONE : RD;
      end
      DONE: begin
        if (Start) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_encryptor.sv
module tb_lfsr_encryptor;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sbq[$];

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_writes = 0;

  int exp_img [64];
  int ks      [64];
  int plain   [64];
  int img1    [64];

  lfsr_encryptor dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Ack         (Ack),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read data memory with write port
  always @(posedge Clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops the next expected write
  always @(negedge Clk) begin
    if (mem_wr_en) begin
      wr_t e;
      n_writes++;
      chk("wr_addr_range", int'(mem_addr >= 8'd64 && mem_addr <= 8'd127), 1);
      if (sbq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", int'(mem_addr), int'(e.addr));
        chk("wr_data", int'(mem_wr_data), int'(e.data));
      end
    end
  end

  function automatic int ones(input int v);
    int c = 0;
    for (int b = 0; b < 8; b++) c += (v >> b) & 1;
    return c;
  endfunction

  // Reference model: keystream and output image from the scheme's rules
  task automatic build_model(input int pre_raw, input int taps_raw, input int seed_raw);
    int pre, taps, s, c7, fb;
    pre  = pre_raw % 16;
    if (pre < 10) pre = 10;
    taps = taps_raw % 128;
    s    = seed_raw % 128;
    if (s == 0) s = 1;
    for (int i = 0; i < 64; i++) begin
      if (i >= pre && i < pre + 52) plain[i] = (int'(mem[i - pre]) - 32 + 256) % 256;
      else plain[i] = 0;
      ks[i] = s;
      c7 = (plain[i] % 128) ^ s;
      exp_img[i] = (ones(c7) % 2) * 128 + c7;
      fb = ones(s & taps) % 2;
      s  = (s * 2) % 128 + fb;
    end
  endtask

  task automatic load_random_msg();
    for (int i = 0; i < 52; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic setup_run(input logic [7:0] pre_raw, input logic [7:0] taps_raw,
                           input logic [7:0] seed_raw);
    mem[61] = pre_raw;
    mem[62] = taps_raw;
    mem[63] = seed_raw;
    for (int i = 64; i < 128; i++) mem[i] = 8'hEE;
    build_model(int'(pre_raw), int'(taps_raw), int'(seed_raw));
    for (int i = 0; i < 64; i++) begin
      wr_t e;
      e.addr = 8'(64 + i);
      e.data = 8'(exp_img[i]);
      sbq.push_back(e);
    end
  endtask

  // Full run from IDLE: Ack timing, write count, decoded image, DONE hold,
  // then a one-cycle Start pulse back to IDLE.
  task automatic run_enc(input logic [7:0] pre_raw, input logic [7:0] taps_raw,
                         input logic [7:0] seed_raw);
    int n, w0;
    bit got;
    setup_run(pre_raw, taps_raw, seed_raw);
    w0 = n_writes;
    @(negedge Clk) Start = 1'b0;
    @(posedge Clk);
    n = 0;
    got = 0;
    while (n < 400 && !got) begin
      @(posedge Clk);
      #1;
      n++;
      if (Ack) got = 1;
    end
    if (!got) chk("ack_timeout", 0, 1);
    else chk("ack_cycle", n, 132);
    @(negedge Clk);
    chk("write_count", n_writes - w0, 64);
    chk("queue_empty", sbq.size(), 0);
    for (int i = 0; i < 64; i++) begin
      chk("img_byte", int'(mem[64 + i]), exp_img[i]);
      chk("img_parity", int'(^mem[64 + i]), 0);
      chk("decrypt", int'(mem[64 + i][6:0]) ^ ks[i], plain[i] % 128);
    end
    w0 = n_writes;
    repeat (5) @(posedge Clk);
    #1;
    chk("done_hold_ack", int'(Ack), 1);
    chk("done_no_writes", n_writes - w0, 0);
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk);
    #1;
    chk("ack_clear", int'(Ack), 0);
  endtask

  initial begin
    int w0;
    logic [7:0] k1 [8];
    string msg;
    k1 = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41, 8'h03};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b1;
    Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ack", int'(Ack), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wr_data", int'(mem_wr_data), 0);
    @(negedge Clk) Reset = 1'b0;

    // Start held high keeps the block idle
    w0 = n_writes;
    repeat (200) @(posedge Clk);
    #1;
    chk("idle_no_writes", n_writes - w0, 0);
    chk("idle_ack", int'(Ack), 0);

    // Scenario 1: taps 0x60, seed 1, pre 15
    load_random_msg();
    run_enc(8'h0F, 8'h60, 8'h01);
    for (int i = 0; i < 8; i++) chk("s1_const", int'(mem[64 + i]), int'(k1[i]));
    for (int i = 0; i < 64; i++) img1[i] = int'(mem[64 + i]);

    // Scenario 2: zero seed behaves like seed 1
    run_enc(8'h0F, 8'h60, 8'h00);
    for (int i = 0; i < 64; i++) chk("s2_same", int'(mem[64 + i]), img1[i]);

    // Scenario 3: preamble clamp, known message
    msg = "Mr. Watson, come here. I want to see you.";
    for (int i = 0; i < 52; i++) mem[i] = (i < msg.len()) ? 8'(msg[i]) : 8'h20;
    run_enc(8'h05, 8'h60, 8'h01);
    chk("s3_m74", int'(mem[74]), 8'h35);
    for (int i = 0; i < 10; i++)
      chk("s3_preamble", int'(mem[64 + i][6:0]), ks[i]);

    // Upper bits of the parameter bytes must be ignored
    load_random_msg();
    run_enc(8'hA7, 8'hE0, 8'h80);

    // Scenario 5: reset during byte 20's RD
    load_random_msg();
    setup_run(8'h0C, 8'h71, 8'h2B);
    w0 = n_writes;
    @(negedge Clk) Start = 1'b0;
    @(posedge Clk);
    repeat (44) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort_ack", int'(Ack), 0);
    chk("abort_wr_en", int'(mem_wr_en), 0);
    @(negedge Clk) Reset = 1'b0;
    chk("abort_writes", n_writes - w0, 20);
    chk("abort_left", sbq.size(), 44);
    sbq.delete();
    repeat (10) @(posedge Clk);
    #1;
    chk("abort_quiet", n_writes - w0, 20);
    run_enc(8'h0C, 8'h71, 8'h2B);

    // Scenario 6: new taps after return to IDLE, plus random parameter runs
    load_random_msg();
    run_enc(8'h0E, 8'h7B, 8'h55);
    for (int r = 0; r < 3; r++) begin
      load_random_msg();
      run_enc(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
